mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single external memory port (20-bit byte address, 128-bit line reads, 32-bit/byte writes) between the instruction-fetch fill path (ic) and the data path (dc).
- Round-robin arbitration, registered request issue, response tag matching against the returned line address, and a timeout-driven read reissue.
- Sits between the ic/dc fill logic and the vi_core memory pins.

Parameters:
- TIMEOUT_CYCLES, 64: cycles from a read issue edge to an automatic reissue if no matching response arrives; legal range >= 2.
- TO_W, 7: timeout counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock, rising edge.
- rsn_i  in  1  reset, asynchronous, active-low.
- ic_req_i  in  1  instruction line-read request; held with ic_addr_i until ic_gnt_o.
- ic_addr_i  in  20  instruction read byte address.
- ic_gnt_o  out  1  one-cycle pulse: ic request accepted.
- ic_ready_o  out  1  one-cycle pulse: ic_data_o valid.
- ic_data_o  out  128  returned line.
- dc_req_i  in  1  data request; held with its controls until dc_gnt_o.
- dc_we_i  in  1  1 = write, 0 = line read.
- dc_byte_i  in  1  write size: 1 = byte, 0 = word.
- dc_addr_i  in  20  data byte address.
- dc_wdata_i  in  32  write data; a byte write uses [7:0].
- dc_gnt_o  out  1  one-cycle pulse: dc request accepted.
- dc_ready_o  out  1  one-cycle pulse: dc_data_o valid (reads only).
- dc_data_o  out  128  returned line.
- mem_read_o  out  1  read strobe, one-cycle pulse.
- mem_read_addr_o  out  20  read address.
- mem_data_ready_i  in  1  response valid.
- mem_data_i  in  128  response line.
- mem_addr_i  in  20  address of the response.
- mem_write_enable_o  out  1  write strobe, one-cycle pulse.
- mem_write_byte_o  out  1  byte-write qualifier.
- mem_write_addr_o  out  20  write address.
- mem_write_data_o  out  32  write data.

Behaviour:
- Reset (rsn_i low, asynchronous): every output is 0.
  - State = IDLE, last_grant = IC, timeout counter = 0, captured address = 0.
- All outputs are registered. FSM states: IDLE, RD_WAIT, WR.
- Arbitration in IDLE:
  - Exactly one requester active: grant it.
  - Both active: grant the one that is not last_grant. After reset, dc wins the first conflict.
  - last_grant updates on every grant, for reads and writes alike.
- Read grant at edge N:
  - ic/dc_gnt_o=1, mem_read_o=1, mem_read_addr_o = requester addr.
  - Capture the owner and addr; counter=0; state=RD_WAIT.
  - At edge N+1 the gnt and mem_read_o return to 0. mem_read_addr_o holds its value.
- In RD_WAIT, a response matches when mem_data_ready_i=1 and mem_addr_i[19:4] == captured addr[19:4].
  - On a match at edge M: the owner's ready_o=1 and data_o=mem_data_i; state=IDLE.
  - ready_o drops at M+1. data_o holds until the next ready for that owner.
  - The earliest next grant is at edge M+1.
- Non-matching responses are ignored in every state. This includes any response seen in IDLE or WR.
- Timeout: the counter increments each RD_WAIT cycle without a match.
  - When it reaches TIMEOUT_CYCLES-1, mem_read_o re-pulses for one cycle with the same address and the counter clears.
  - Reissue pulses are therefore exactly TIMEOUT_CYCLES edges apart. There is no retry limit.
  - A match on the same edge as a reissue wins: no reissue pulse occurs.
- dc write grant at edge N:
  - dc_gnt_o=1, mem_write_enable_o=1, mem_write_byte_o=dc_byte_i, mem_write_addr_o=dc_addr_i, mem_write_data_o=dc_wdata_i; state=WR.
  - At edge N+1 the strobe and gnt drop and state=IDLE. The write is posted; there is no dc_ready_o.
- A read and a write are never issued on the same edge. Only one transaction is outstanding at a time.
- A request deasserted before its grant is dropped silently. A requester may not re-request a read before its ready_o.
- Reset mid-read abandons the read. A response after reset is ignored.

Test Plan:
- ic read 0x08000, memory replies one cycle after strobe -> ic_gnt_o and mem_read_o pulse together with addr 0x08000; ic_ready_o pulses 2 edges later with ic_data_o = {00108093,00208663,00500113,00000093}.
- ic and dc reads raised together right after reset and held -> grant order dc, ic, dc, ic; each grant waits for the previous ready.
- dc byte write addr 0x0A003, data 0x000000AB -> one-cycle mem_write_enable_o=1, mem_write_byte_o=1, mem_write_addr_o=0x0A003, mem_write_data_o=0xAB; dc_gnt_o pulse; dc_ready_o stays 0.
- Waiting on 0x08000, inject ready with mem_addr_i=0x01000 -> no ready_o; a later ready with 0x08004 (same line) -> ic_ready_o pulse.
- TIMEOUT_CYCLES=8, memory silent -> mem_read_o pulses at N, N+8, N+16 with unchanged address; replying after the third pulse completes the read.
- Assert rsn_i low during RD_WAIT -> all outputs 0 immediately; a response delivered after release produces no ready_o.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port between ic and dc.
// Registered issue, line-tag response matching and timeout read reissue.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_W           = 7
) (
    input  logic         clk_i,
    input  logic         rsn_i,
    input  logic         ic_req_i,
    input  logic [19:0]  ic_addr_i,
    output logic         ic_gnt_o,
    output logic         ic_ready_o,
    output logic [127:0] ic_data_o,
    input  logic         dc_req_i,
    input  logic         dc_we_i,
    input  logic         dc_byte_i,
    input  logic [19:0]  dc_addr_i,
    input  logic [31:0]  dc_wdata_i,
    output logic         dc_gnt_o,
    output logic         dc_ready_o,
    output logic [127:0] dc_data_o,
    output logic         mem_read_o,
    output logic [19:0]  mem_read_addr_o,
    input  logic         mem_data_ready_i,
    input  logic [127:0] mem_data_i,
    input  logic [19:0]  mem_addr_i,
    output logic         mem_write_enable_o,
    output logic         mem_write_byte_o,
    output logic [19:0]  mem_write_addr_o,
    output logic [31:0]  mem_write_data_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t         state_q, state_d;
    logic           last_q, last_d;
    logic           own_q, own_d;
    logic [19:0]    addr_q, addr_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic           ic_gnt_q, ic_gnt_d;
    logic           dc_gnt_q, dc_gnt_d;
    logic           ic_rdy_q, ic_rdy_d;
    logic           dc_rdy_q, dc_rdy_d;
    logic [127:0]   ic_data_q, ic_data_d;
    logic [127:0]   dc_data_q, dc_data_d;
    logic           rd_q, rd_d;
    logic [19:0]    rd_addr_q, rd_addr_d;
    logic           we_q, we_d;
    logic           wb_q, wb_d;
    logic [19:0]    wa_q, wa_d;
    logic [31:0]    wd_q, wd_d;

    logic pick_dc;
    logic match;

    // last_q: 1 = dc was granted last, so ic wins the next conflict
    assign pick_dc = dc_req_i && (!ic_req_i || !last_q);
    assign match   = mem_data_ready_i && (mem_addr_i[19:4] == addr_q[19:4]);

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        own_d     = own_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        ic_gnt_d  = 1'b0;
        dc_gnt_d  = 1'b0;
        ic_rdy_d  = 1'b0;
        dc_rdy_d  = 1'b0;
        ic_data_d = ic_data_q;
        dc_data_d = dc_data_q;
        rd_d      = 1'b0;
        rd_addr_d = rd_addr_q;
        we_d      = 1'b0;
        wb_d      = wb_q;
        wa_d      = wa_q;
        wd_d      = wd_q;
        unique case (state_q)
            IDLE: begin
                if (pick_dc) begin
                    dc_gnt_d = 1'b1;
                    last_d   = 1'b1;
                    if (dc_we_i) begin
                        we_d    = 1'b1;
                        wb_d    = dc_byte_i;
                        wa_d    = dc_addr_i;
                        wd_d    = dc_wdata_i;
                        state_d = WR;
                    end else begin
                        rd_d      = 1'b1;
                        rd_addr_d = dc_addr_i;
                        addr_d    = dc_addr_i;
                        own_d     = 1'b1;
                        cnt_d     = '0;
                        state_d   = RD_WAIT;
                    end
                end else if (ic_req_i) begin
                    ic_gnt_d  = 1'b1;
                    last_d    = 1'b0;
                    rd_d      = 1'b1;
                    rd_addr_d = ic_addr_i;
                    addr_d    = ic_addr_i;
                    own_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (match) begin
                    state_d = IDLE;
                    if (own_q) begin
                        dc_rdy_d  = 1'b1;
                        dc_data_d = mem_data_i;
                    end else begin
                        ic_rdy_d  = 1'b1;
                        ic_data_d = mem_data_i;
                    end
                end else if (cnt_q == TO_LAST) begin
                    rd_d  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q   <= IDLE;
            last_q    <= 1'b0;
            own_q     <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            ic_gnt_q  <= 1'b0;
            dc_gnt_q  <= 1'b0;
            ic_rdy_q  <= 1'b0;
            dc_rdy_q  <= 1'b0;
            ic_data_q <= '0;
            dc_data_q <= '0;
            rd_q      <= 1'b0;
            rd_addr_q <= '0;
            we_q      <= 1'b0;
            wb_q      <= 1'b0;
            wa_q      <= '0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            own_q     <= own_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            ic_gnt_q  <= ic_gnt_d;
            dc_gnt_q  <= dc_gnt_d;
            ic_rdy_q  <= ic_rdy_d;
            dc_rdy_q  <= dc_rdy_d;
            ic_data_q <= ic_data_d;
            dc_data_q <= dc_data_d;
            rd_q      <= rd_d;
            rd_addr_q <= rd_addr_d;
            we_q      <= we_d;
            wb_q      <= wb_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
        end
    end

    assign ic_gnt_o           = ic_gnt_q;
    assign ic_ready_o         = ic_rdy_q;
    assign ic_data_o          = ic_data_q;
    assign dc_gnt_o           = dc_gnt_q;
    assign dc_ready_o         = dc_rdy_q;
    assign dc_data_o          = dc_data_q;
    assign mem_read_o         = rd_q;
    assign mem_read_addr_o    = rd_addr_q;
    assign mem_write_enable_o = we_q;
    assign mem_write_byte_o   = wb_q;
    assign mem_write_addr_o   = wa_q;
    assign mem_write_data_o   = wd_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with TIMEOUT_CYCLES = 8.
// Hand-computed expectations, all compared through chk().
module tb_mem_port_arbiter;

    logic         clk = 1'b0;
    logic         rsn;
    logic         ic_req;
    logic [19:0]  ic_addr;
    logic         ic_gnt, ic_ready;
    logic [127:0] ic_data;
    logic         dc_req, dc_we, dc_byte;
    logic [19:0]  dc_addr;
    logic [31:0]  dc_wdata;
    logic         dc_gnt, dc_ready;
    logic [127:0] dc_data;
    logic         mem_read;
    logic [19:0]  mem_read_addr;
    logic         mem_rdy;
    logic [127:0] mem_data;
    logic [19:0]  mem_addr;
    logic         mem_we, mem_wb;
    logic [19:0]  mem_wa;
    logic [31:0]  mem_wd;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] LINE0 =
        {32'h00108093, 32'h00208663, 32'h00500113, 32'h00000093};

    mem_port_arbiter #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut (
        .clk_i(clk), .rsn_i(rsn),
        .ic_req_i(ic_req), .ic_addr_i(ic_addr),
        .ic_gnt_o(ic_gnt), .ic_ready_o(ic_ready), .ic_data_o(ic_data),
        .dc_req_i(dc_req), .dc_we_i(dc_we), .dc_byte_i(dc_byte),
        .dc_addr_i(dc_addr), .dc_wdata_i(dc_wdata),
        .dc_gnt_o(dc_gnt), .dc_ready_o(dc_ready), .dc_data_o(dc_data),
        .mem_read_o(mem_read), .mem_read_addr_o(mem_read_addr),
        .mem_data_ready_i(mem_rdy), .mem_data_i(mem_data),
        .mem_addr_i(mem_addr),
        .mem_write_enable_o(mem_we), .mem_write_byte_o(mem_wb),
        .mem_write_addr_o(mem_wa), .mem_write_data_o(mem_wd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rsn = 1'b0;
        step();
        step();
        rsn = 1'b1;
    endtask

    logic [127:0] zero_or;
    int n;
    int pulses;
    logic [1:0] want;

    initial begin
        rsn = 1'b1; ic_req = 0; ic_addr = '0; dc_req = 0; dc_we = 0;
        dc_byte = 0; dc_addr = '0; dc_wdata = '0;
        mem_rdy = 0; mem_data = '0; mem_addr = '0;
        #2 rsn = 1'b0;
        #1;
        zero_or = {126'h0, ic_gnt, ic_ready} | ic_data | dc_data
                | {127'h0, dc_gnt | dc_ready | mem_read | mem_we | mem_wb}
                | {108'h0, mem_read_addr} | {108'h0, mem_wa}
                | {96'h0, mem_wd};
        chk("reset_outputs", zero_or, '0);
        step();
        rsn = 1'b1;

        // ic read, memory replies one cycle after the strobe
        ic_req = 1; ic_addr = 20'h08000;
        step();
        chk("ic_gnt", ic_gnt, 1);
        chk("ic_rd", mem_read, 1);
        chk("ic_rd_addr", mem_read_addr, 20'h08000);
        ic_req = 0;
        step();
        chk("ic_rd_drop", {ic_gnt, mem_read}, 0);
        chk("ic_addr_hold", mem_read_addr, 20'h08000);
        mem_rdy = 1; mem_addr = 20'h08000; mem_data = LINE0;
        step();
        chk("ic_ready", ic_ready, 1);
        chk("ic_data", ic_data, LINE0);
        mem_rdy = 0;
        step();
        chk("ic_ready_drop", ic_ready, 0);
        chk("ic_data_hold", ic_data, LINE0);

        // conflicting held reads after reset: dc, ic, dc, ic
        do_reset();
        ic_req = 1; ic_addr = 20'h01230;
        dc_req = 1; dc_we = 0; dc_addr = 20'h04560;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            step();
            while (!(ic_gnt || dc_gnt) && n < 10) begin
                step();
                n++;
            end
            chk("rr_gnt_wait", n < 10, 1);
            want = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("rr_order", {ic_gnt, dc_gnt}, want);
            step();
            mem_rdy = 1;
            mem_addr = want[0] ? 20'h04560 : 20'h01230;
            mem_data = {108'h0, mem_addr};
            step();
            chk("rr_ready", {ic_ready, dc_ready}, want);
            if (k == 3) begin
                ic_req = 0;
                dc_req = 0;
            end
            mem_rdy = 0;
        end
        chk("rr_dc_data", dc_data, {108'h0, 20'h04560});

        // dc byte write
        step();
        dc_req = 1; dc_we = 1; dc_byte = 1;
        dc_addr = 20'h0A003; dc_wdata = 32'h000000AB;
        step();
        chk("wr_gnt", dc_gnt, 1);
        chk("wr_strobe", {mem_we, mem_wb, mem_read}, 3'b110);
        chk("wr_addr", mem_wa, 20'h0A003);
        chk("wr_data", mem_wd, 32'hAB);
        dc_req = 0; dc_we = 0; dc_byte = 0;
        step();
        chk("wr_drop", {mem_we, dc_gnt, dc_ready}, 0);

        // mismatched response ignored, same-line response accepted
        ic_req = 1; ic_addr = 20'h08000;
        step();
        chk("mm_gnt", ic_gnt, 1);
        ic_req = 0;
        mem_rdy = 1; mem_addr = 20'h01000; mem_data = '1;
        step();
        chk("mm_ignored", ic_ready, 0);
        mem_rdy = 0;
        step();
        mem_rdy = 1; mem_addr = 20'h08004; mem_data = {4{32'h5A5A1234}};
        step();
        chk("mm_line_match", ic_ready, 1);
        chk("mm_data", ic_data, {4{32'h5A5A1234}});
        mem_addr = 20'h08000; mem_data = '0;
        step();
        chk("idle_resp_ignored", ic_ready, 0);
        mem_rdy = 0;

        // timeout reissue every 8 edges, then reply
        ic_req = 1; ic_addr = 20'h0C000;
        step();
        chk("to_issue", mem_read, 1);
        ic_req = 0;
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (mem_read) pulses++;
            if (i == 8) chk("to_pulse8", mem_read, 1);
            if (i == 16) chk("to_pulse16", mem_read, 1);
        end
        chk("to_pulse_count", pulses, 2);
        chk("to_addr", mem_read_addr, 20'h0C000);
        mem_rdy = 1; mem_addr = 20'h0C008; mem_data = {108'h0, 20'h0C008};
        step();
        chk("to_ready", ic_ready, 1);
        mem_rdy = 0;

        // match on the reissue edge wins
        step();
        dc_req = 1; dc_we = 0; dc_addr = 20'h0D000;
        step();
        chk("mr_gnt", {dc_gnt, mem_read}, 2'b11);
        dc_req = 0;
        for (int i = 1; i <= 7; i++) step();
        mem_rdy = 1; mem_addr = 20'h0D000; mem_data = {4{32'hCAFEF00D}};
        step();
        chk("mr_ready_no_reissue", {dc_ready, mem_read}, 2'b10);
        chk("mr_data", dc_data, {4{32'hCAFEF00D}});
        mem_rdy = 0;

        // reset during RD_WAIT abandons the read
        step();
        ic_req = 1; ic_addr = 20'h0E000;
        step();
        chk("rst_gnt", ic_gnt, 1);
        ic_req = 0;
        step();
        #2 rsn = 1'b0;
        #1;
        zero_or = {126'h0, ic_gnt, ic_ready} | ic_data | dc_data
                | {127'h0, dc_gnt | dc_ready | mem_read | mem_we | mem_wb}
                | {108'h0, mem_read_addr} | {108'h0, mem_wa}
                | {96'h0, mem_wd};
        chk("rst_mid_outputs", zero_or, '0);
        step();
        rsn = 1'b1;
        mem_rdy = 1; mem_addr = 20'h0E000; mem_data = '1;
        step();
        chk("rst_resp_ignored", ic_ready, 0);
        mem_rdy = 0;
        step();
        chk("rst_data_clear", ic_data, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
